vga_frame_ctrl: RTL
===================

# vga_frame_ctrl

Frame-synchronous controller for the VGA ball peripheral on the Avalon-MM lightweight bus. It generates 640×480@60 Hz raster timing from the 50 MHz fabric clock and holds a software-visible register file. Ball position, colour and enable are double-buffered: software writes pending registers, and the block commits them atomically to the active outputs at the start of vertical blank, so the pixel datapath never shows a torn frame. It sits between the HPS bridge and the pixel shader/VGA pins.

## Interface

Parameters:
- `HACTIVE`, default 1280: active clocks per line (2 clk per pixel).
- `HFP`, `HSYNC`, `HBP`, defaults 32 / 192 / 96: horizontal front porch, sync and back porch; line total is 1600.
- `VACTIVE`, default 480: active lines.
- `VFP`, `VSYNC`, `VBP`, defaults 10 / 2 / 33: vertical front porch, sync and back porch; frame total is 525.

Ports:
- `clk` in, 1 bit: 50 MHz. One clock; reset is synchronous and active-high.
- `reset` in, 1 bit: synchronous, active-high.
- `chipselect` in, 1 bit: Avalon select.
- `write` in, 1 bit: write strobe; valid only with `chipselect`.
- `read` in, 1 bit: read strobe; valid only with `chipselect`.
- `address` in, 3 bits: word address.
- `writedata` in, 16 bits: write data.
- `readdata` out, 16 bits: registered read data.
- `hcount` out, 11 bits: 0..1599.
- `vcount` out, 10 bits: 0..524.
- `vga_clk` out, 1 bit: equal to `hcount[0]`.
- `vga_hs` out, 1 bit: low while `hcount` is in 1312..1503.
- `vga_vs` out, 1 bit: low while `vcount` is in 490..491.
- `vga_blank_n` out, 1 bit: high while `hcount`<1280 and `vcount`<480.
- `vga_sync_n` out, 1 bit: constant 0.
- `ball_x` out, 10 bits: active x position.
- `ball_y` out, 10 bits: active y position.
- `ball_r`, `ball_g`, `ball_b` out, 8 bits each: active colour.
- `ball_en` out, 1 bit: active enable.

## Operation

- Raster counters:
  - `hcount` increments every clk and wraps 1599→0.
  - `vcount` increments when `hcount` wraps, and wraps 524→0.
  - All sync and blank outputs are decoded combinationally from the counter registers.
- Register map (word address):
  - 0: X [9:0]
  - 1: Y [9:0]
  - 2: {R[15:8], G[7:0]}
  - 3: {8'b0, B[7:0]}
  - 4: CTRL, bit0 = enable
  - 5: STATUS (read-only): bit0 `pending`, bit1 `in_vblank` (`vcount`>=480), [15:8] = frame_count[7:0]
  - 6: FRAME_CNT (read-only, 16 bits)
  - 7: reads 0
- Unused write bits are ignored and read back as 0. Writes to addresses 5–7 are ignored.
- Writes to addresses 0–4 update the pending copy and set `pending`=1. Reads of 0–4 return the pending copy.
- Commit point: the cycle in which `hcount`==1599 and `vcount`==479, i.e. the last clk before blank begins. On that cycle:
  - If `pending`: copy pending→active and clear `pending`.
  - In all cases, frame_count increments (16-bit, wraps 0xFFFF→0).
- Simultaneous write and commit in the same cycle:
  - The commit uses the pre-write pending values.
  - The write lands in pending.
  - `pending` ends at 1, so the new value commits at the next frame.
- Reset values:
  - `hcount`=0, `vcount`=0.
  - Pending and active: X=320, Y=240, R=G=B=0xFF, enable=0.
  - `pending`=0, frame_count=0, `readdata`=0.
  - Resulting output levels: `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=1, `vga_clk`=0, `ball_en`=0.
- Reset asserted mid-frame: all state returns to the reset values on the next edge; no partial commit occurs.

## Timing

- Read latency is 1 cycle: `readdata` is registered on the cycle `chipselect`&`read` is high. `readdata` holds its value otherwise.
- Write latency: the pending register changes on the edge that samples `chipselect`&`write`.
- Active outputs change only on the edge that ends the commit cycle. They are stable through every visible line.
- No wait states and no backpressure.

## Structure

- Package `vga_ctrl_pkg`:
  - Timing localparams (totals, sync start/end).
  - Register address constants.
  - `ball_regs_t` packed struct {x, y, r, g, b, en}, used for both the pending and active copies.
- Sub-module `vga_timing_gen`:
  - Contents: counters plus sync and blank decode.
  - Extra output: one-cycle `frame_end` pulse, driving the commit logic.
- Top: Avalon decode, pending/active `ball_regs_t`, `pending` flag, frame counter, read mux.

## Test plan

- Reset, then run 840,000 clk:
  - `hcount` wraps every 1600 clk and `vcount` every 525 lines.
  - `vga_hs` low for exactly 192 clk per line; `vga_vs` low for exactly 2 lines (3200 clk).
  - FRAME_CNT reads 1 after the first commit point.
- Write X=100 at `vcount`=100:
  - `ball_x` stays 320 until the commit edge, then becomes 100.
  - STATUS bit0 reads 1 before the commit and 0 after it.
- Write R/G=0x12_34 in the exact commit cycle:
  - Active colour is unchanged this frame.
  - `pending`=1 afterwards.
  - `ball_r`=0x12 and `ball_g`=0x34 after the next commit.
- Read addr 2 with pending 0xABCD: `readdata`=0xABCD one cycle after the read. Read addr 7: `readdata`=0.
- Assert `reset` at `vcount`=300 with a write pending:
  - Next cycle: counters 0, `ball_x`=320, `pending`=0, FRAME_CNT=0.
- Force frame_count to 0xFFFF (65,535 frames, or via hierarchical force): after the next commit, FRAME_CNT=0x0000 and STATUS[15:8]=0x00.

Source files
------------

// File: rtl/vga_frame_ctrl_pkg.sv
// Shared timing constants, register map and ball register type for the
// VGA ball frame controller.
package vga_ctrl_pkg;

  // Default 640x480@60 raster, two fabric clocks per pixel
  localparam int H_ACTIVE_DEF     = 1280;
  localparam int H_FP_DEF         = 32;
  localparam int H_SYNC_DEF       = 192;
  localparam int H_BP_DEF         = 96;
  localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;

  localparam int V_ACTIVE_DEF     = 480;
  localparam int V_FP_DEF         = 10;
  localparam int V_SYNC_DEF       = 2;
  localparam int V_BP_DEF         = 33;
  localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  // Word addresses on the Avalon slave
  localparam logic [2:0] ADDR_X      = 3'd0;
  localparam logic [2:0] ADDR_Y      = 3'd1;
  localparam logic [2:0] ADDR_RG     = 3'd2;
  localparam logic [2:0] ADDR_B      = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_FRAME  = 3'd6;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       en;
  } ball_regs_t;

  localparam ball_regs_t BALL_RESET = '{x: 10'd320, y: 10'd240,
                                        r: 8'hFF, g: 8'hFF, b: 8'hFF,
                                        en: 1'b0};

  // True for the writable ball registers (X, Y, RG, B, CTRL)
  function automatic logic is_ball_addr(input logic [2:0] a);
    return (a <= ADDR_CTRL);
  endfunction

endpackage

// File: rtl/vga_frame_ctrl_if.sv
// Avalon-MM lightweight slave bundle between the HPS bridge and the controller.
interface vga_frame_ctrl_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [2:0]  address;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output chipselect, output write, output read,
                  output address, output writedata, input readdata);
  modport slave  (input chipselect, input write, input read,
                  input address, input writedata, output readdata);
endinterface

// File: rtl/vga_frame_ctrl_timing_gen.sv
// Raster counters with sync/blank decode and an end-of-visible-frame pulse.
module vga_timing_gen
  import vga_ctrl_pkg::*;
#(
  parameter int HACTIVE = H_ACTIVE_DEF,
  parameter int HFP     = H_FP_DEF,
  parameter int HSYNC   = H_SYNC_DEF,
  parameter int HBP     = H_BP_DEF,
  parameter int VACTIVE = V_ACTIVE_DEF,
  parameter int VFP     = V_FP_DEF,
  parameter int VSYNC   = V_SYNC_DEF,
  parameter int VBP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] o_hcount,
  output logic [9:0]  o_vcount,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_blank_n,
  output logic        o_frame_end
);

  localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;
  localparam int HSS    = HACTIVE + HFP;
  localparam int HSE    = HSS + HSYNC - 1;
  localparam int VSS    = VACTIVE + VFP;
  localparam int VSE    = VSS + VSYNC - 1;

  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        w_hwrap;
  logic        w_vwrap;

  assign w_hwrap = (r_hcount == 11'(HTOTAL - 1));
  assign w_vwrap = (r_vcount == 10'(VTOTAL - 1));

  // Horizontal counter, wraps at end of line
  always_ff @(posedge clk) begin
    if (reset)        r_hcount <= '0;
    else if (w_hwrap) r_hcount <= '0;
    else              r_hcount <= r_hcount + 11'd1;
  end

  // Vertical counter, advances on each line wrap
  always_ff @(posedge clk) begin
    if (reset)                    r_vcount <= '0;
    else if (w_hwrap && w_vwrap)  r_vcount <= '0;
    else if (w_hwrap)             r_vcount <= r_vcount + 10'd1;
  end

  assign o_hcount    = r_hcount;
  assign o_vcount    = r_vcount;
  assign o_hs        = ~((r_hcount >= 11'(HSS)) && (r_hcount <= 11'(HSE)));
  assign o_vs        = ~((r_vcount >= 10'(VSS)) && (r_vcount <= 10'(VSE)));
  assign o_blank_n   = (r_hcount < 11'(HACTIVE)) && (r_vcount < 10'(VACTIVE));
  // Last clock of the last visible line: the commit point
  assign o_frame_end = w_hwrap && (r_vcount == 10'(VACTIVE - 1));

endmodule

// File: rtl/vga_frame_ctrl.sv
// VGA ball frame controller: raster timing plus a double-buffered register
// file whose pending copy is committed to the active outputs at vblank start.
module vga_frame_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int HACTIVE = H_ACTIVE_DEF,
  parameter int HFP     = H_FP_DEF,
  parameter int HSYNC   = H_SYNC_DEF,
  parameter int HBP     = H_BP_DEF,
  parameter int VACTIVE = V_ACTIVE_DEF,
  parameter int VFP     = V_FP_DEF,
  parameter int VSYNC   = V_SYNC_DEF,
  parameter int VBP     = V_BP_DEF
) (
  input  logic                clk,
  input  logic                reset,
  vga_frame_ctrl_if.slave     avs,
  output logic [10:0]         hcount,
  output logic [9:0]          vcount,
  output logic                vga_clk,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_blank_n,
  output logic                vga_sync_n,
  output logic [9:0]          ball_x,
  output logic [9:0]          ball_y,
  output logic [7:0]          ball_r,
  output logic [7:0]          ball_g,
  output logic [7:0]          ball_b,
  output logic                ball_en
);

  logic        w_frame_end;
  logic        w_wr;
  logic        w_wr_ball;
  logic        w_rd;
  logic        w_in_vblank;
  logic [15:0] w_rdata;

  ball_regs_t  r_pend;
  ball_regs_t  r_act;
  logic        r_pending;
  logic [15:0] r_frame_cnt;
  logic [15:0] r_readdata;

  vga_timing_gen #(
    .HACTIVE(HACTIVE), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
    .VACTIVE(VACTIVE), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .o_hcount   (hcount),
    .o_vcount   (vcount),
    .o_hs       (vga_hs),
    .o_vs       (vga_vs),
    .o_blank_n  (vga_blank_n),
    .o_frame_end(w_frame_end)
  );

  assign vga_clk     = hcount[0];
  assign vga_sync_n  = 1'b0;
  assign w_wr        = avs.chipselect & avs.write;
  assign w_wr_ball   = w_wr & is_ball_addr(avs.address);
  assign w_rd        = avs.chipselect & avs.read;
  assign w_in_vblank = (vcount >= 10'(VACTIVE));

  // Software writes land in the pending copy only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= BALL_RESET;
    end else if (w_wr) begin
      case (avs.address)
        ADDR_X:    r_pend.x  <= avs.writedata[9:0];
        ADDR_Y:    r_pend.y  <= avs.writedata[9:0];
        ADDR_RG:   {r_pend.r, r_pend.g} <= avs.writedata;
        ADDR_B:    r_pend.b  <= avs.writedata[7:0];
        ADDR_CTRL: r_pend.en <= avs.writedata[0];
        default:   ;
      endcase
    end
  end

  // Pending flag: a write wins over the commit clear so a same-cycle write
  // is carried into the next frame
  always_ff @(posedge clk) begin
    if (reset)            r_pending <= 1'b0;
    else if (w_wr_ball)   r_pending <= 1'b1;
    else if (w_frame_end) r_pending <= 1'b0;
  end

  // Atomic commit of pending to active at the commit point
  always_ff @(posedge clk) begin
    if (reset)                         r_act <= BALL_RESET;
    else if (w_frame_end && r_pending) r_act <= r_pend;
  end

  // Frame counter, one tick per commit point
  always_ff @(posedge clk) begin
    if (reset)            r_frame_cnt <= '0;
    else if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  // Read mux over the pending copy and status
  always_comb begin
    w_rdata = '0;
    case (avs.address)
      ADDR_X:      w_rdata = {6'b0, r_pend.x};
      ADDR_Y:      w_rdata = {6'b0, r_pend.y};
      ADDR_RG:     w_rdata = {r_pend.r, r_pend.g};
      ADDR_B:      w_rdata = {8'b0, r_pend.b};
      ADDR_CTRL:   w_rdata = {15'b0, r_pend.en};
      ADDR_STATUS: w_rdata = {r_frame_cnt[7:0], 6'b0, w_in_vblank, r_pending};
      ADDR_FRAME:  w_rdata = r_frame_cnt;
      default:     w_rdata = '0;
    endcase
  end

  // Registered read data, held between reads
  always_ff @(posedge clk) begin
    if (reset)     r_readdata <= '0;
    else if (w_rd) r_readdata <= w_rdata;
  end

  assign avs.readdata = r_readdata;
  assign ball_x  = r_act.x;
  assign ball_y  = r_act.y;
  assign ball_r  = r_act.r;
  assign ball_g  = r_act.g;
  assign ball_b  = r_act.b;
  assign ball_en = r_act.en;

endmodule
